// File: rtl/medidor_frequencia.sv
`default_nettype none
// ============================================================================
// medidor_frequencia : counts rising edges of sinal_in per GATE_CYCLES window
//                      and publishes the saturated 8-bit result.
// Optional macro     : MEDIDOR_PICO_EN (peak-hold numero, sticky estouro)
// Revision           : 1.0
// ============================================================================
module medidor_frequencia #(
   parameter int GATE_CYCLES = 5_000_000,
   parameter int GATE_W      = 23
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sinal_in,
   output logic [7:0] numero,
   output logic       pronto,
   output logic       estouro
);

   localparam logic [GATE_W-1:0] C_G_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [8:0]        C_C_SAT  = 9'd256;

   logic              s1_q, s2_q, s3_q;
   logic [2:0]        vld_q;
   logic [GATE_W-1:0] g_q, g_d;
   logic [8:0]        c_q, c_d;
   logic [7:0]        numero_q, numero_d;
   logic              pronto_q, pronto_d;
   logic              estouro_q, estouro_d;

   logic              w_borda;
   logic              w_terminal;
   logic [9:0]        w_sum;
   logic [8:0]        w_total;
   logic              w_ovf;
   logic [7:0]        w_sat;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         vld_q     <= 3'b000;
         g_q       <= '0;
         c_q       <= '0;
         numero_q  <= '0;
         pronto_q  <= 1'b0;
         estouro_q <= 1'b0;
      end else begin
         s1_q      <= sinal_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         vld_q     <= {vld_q[1:0], 1'b1};
         g_q       <= g_d;
         c_q       <= c_d;
         numero_q  <= numero_d;
         pronto_q  <= pronto_d;
         estouro_q <= estouro_d;
      end
   end

   // s3 only holds a genuine sample once vld_q[2] is set; until then a high
   // input present at reset release must not look like a rising edge.
   assign w_borda    = s2_q & ~s3_q & vld_q[2];
   assign w_terminal = (g_q == C_G_LAST);
   assign w_sum      = {1'b0, c_q} + {9'd0, w_borda};
   assign w_total    = (w_sum > {1'b0, C_C_SAT}) ? C_C_SAT : w_sum[8:0];
   assign w_ovf      = w_total[8];
   assign w_sat      = w_ovf ? 8'hFF : w_total[7:0];

   always_comb begin
      g_d       = g_q + GATE_W'(1);
      c_d       = w_total;
      pronto_d  = 1'b0;
      numero_d  = numero_q;
      estouro_d = estouro_q;
      if (w_terminal) begin
         g_d      = '0;
         c_d      = '0;
         pronto_d = 1'b1;
`ifdef MEDIDOR_PICO_EN
         if (w_sat > numero_q) begin
            numero_d = w_sat;
         end
         estouro_d = estouro_q | w_ovf;
`else
         numero_d  = w_sat;
         estouro_d = w_ovf;
`endif
      end
   end

   assign numero  = numero_q;
   assign pronto  = pronto_q;
   assign estouro = estouro_q;

endmodule
`default_nettype wire
